// File: rtl/fetch_decode_buffer.sv
// IF/ID pipeline register: pairs an opcode word flagged as carrying an immediate with the
// following fetched word, emitting one Decode packet per instruction and bubbles in between.
module fetch_decode_buffer #(
   parameter int                WORD_W       = 16,
   parameter int                PC_W         = 32,
   parameter int                IMM_FLAG_BIT = 13,
   parameter logic [WORD_W-1:0] NOP_WORD     = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [WORD_W-1:0] if_instr,
   input  logic [PC_W-1:0]   if_pc_next,
   input  logic              stall,
   input  logic              flush,
   output logic              id_valid,
   output logic [WORD_W-1:0] id_instr,
   output logic [WORD_W-1:0] id_imm,
   output logic              id_has_imm,
   output logic [PC_W-1:0]   id_pc_next,
   output logic              wait_imm
);

   // Handshake: Fetch offers a word with if_valid and it is consumed on any edge where
   // stall and flush are both low; there is no back-pressure beyond stall. id_valid marks
   // a real packet for exactly the cycles it is presented, bubbles carry NOP_WORD.
   typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

   state_t            state;
   logic [WORD_W-1:0] held;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_OP;
         held       <= NOP_WORD;
         id_valid   <= 1'b0;
         id_instr   <= NOP_WORD;
         id_imm     <= NOP_WORD;
         id_has_imm <= 1'b0;
         id_pc_next <= '0;
         wait_imm   <= 1'b0;
      end else if (flush) begin
         state      <= S_OP;
         held       <= NOP_WORD;
         id_valid   <= 1'b0;
         id_instr   <= NOP_WORD;
         id_imm     <= NOP_WORD;
         id_has_imm <= 1'b0;
         id_pc_next <= '0;
         wait_imm   <= 1'b0;
      end else if (stall) begin
         state <= state;
      end else if (!if_valid) begin
         // Bubble with no input; a half-collected pair stays parked.
         id_valid   <= 1'b0;
         id_instr   <= NOP_WORD;
         id_imm     <= NOP_WORD;
         id_has_imm <= 1'b0;
      end else begin
         case (state)
            S_OP: begin
               if (if_instr[IMM_FLAG_BIT]) begin
                  held       <= if_instr;
                  state      <= S_IMM;
                  wait_imm   <= 1'b1;
                  id_valid   <= 1'b0;
                  id_instr   <= NOP_WORD;
                  id_imm     <= NOP_WORD;
                  id_has_imm <= 1'b0;
               end else begin
                  id_valid   <= 1'b1;
                  id_instr   <= if_instr;
                  id_imm     <= NOP_WORD;
                  id_has_imm <= 1'b0;
                  id_pc_next <= if_pc_next;
               end
            end
            S_IMM: begin
               // The immediate is raw data; its flag bit is deliberately not examined.
               id_valid   <= 1'b1;
               id_instr   <= held;
               id_imm     <= if_instr;
               id_has_imm <= 1'b1;
               id_pc_next <= if_pc_next;
               held       <= NOP_WORD;
               state      <= S_OP;
               wait_imm   <= 1'b0;
            end
            default: begin
               state    <= S_OP;
               wait_imm <= 1'b0;
            end
         endcase
      end
   end

endmodule
